// File: rtl/hba_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : hba_reg_bank
// Description : HBA bus slave. It terminates master transfers that hit this
//               peripheral number and holds NUM_REGS byte-wide registers:
//                 reg0          INT_EN      (R/W)
//                 reg1          INT_STATUS  (read, bus write-1-to-clear,
//                                            set by slv_int_set pulses)
//                 reg2..N-1     general purpose (R/W from bus, loadable
//                                            from peripheral write ports)
//               Each accepted transfer is answered with a single-cycle
//               xferack. The slave then waits for select to drop before it
//               will accept another transfer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   hba_clk              in   bus clock, rising edge
//   hba_resetq           in   asynchronous active-low reset
//   hba_abus             in   {peripheral number, register index}
//   hba_rnw              in   1 = read, 0 = write
//   hba_select           in   transfer in progress
//   hba_dbus             in   master write data
//   hba_xferack_slave    out  transfer complete, one cycle
//   hba_dbus_slave       out  read data, zero outside the ack cycle
//   hba_interrupt_slave  out  registered |(INT_EN & INT_STATUS)
//   slv_regs             out  all registers, reg i at [i*DBUS_WIDTH +: DBUS_WIDTH]
//   slv_wr_en            in   peripheral write enable per register (0,1 unused)
//   slv_wr_data          in   peripheral write data, same packing as slv_regs
//   slv_int_set          in   INT_STATUS set pulses
//   reg_wr_pulse         out  one-cycle strobe per register written by the bus
// ============================================================================
module hba_reg_bank #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_REGS          = 4
) (
  input  logic                           hba_clk,
  input  logic                           hba_resetq,
  input  logic [ADDR_WIDTH-1:0]          hba_abus,
  input  logic                           hba_rnw,
  input  logic                           hba_select,
  input  logic [DBUS_WIDTH-1:0]          hba_dbus,
  output logic                           hba_xferack_slave,
  output logic [DBUS_WIDTH-1:0]          hba_dbus_slave,
  output logic                           hba_interrupt_slave,
  output logic [NUM_REGS*DBUS_WIDTH-1:0] slv_regs,
  input  logic [NUM_REGS-1:0]            slv_wr_en,
  input  logic [NUM_REGS*DBUS_WIDTH-1:0] slv_wr_data,
  input  logic [DBUS_WIDTH-1:0]          slv_int_set,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE       = 2'd0;
  localparam logic [1:0] c_ST_ACK        = 2'd1;
  localparam logic [1:0] c_ST_WAIT_DESEL = 2'd2;

  localparam logic [PERIPH_ADDR_WIDTH-1:0] c_PERIPH = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);

  localparam int c_IDX_INT_EN     = 0;
  localparam int c_IDX_INT_STATUS = 1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]                           r_state;
  logic [1:0]                           w_state_nxt;

  logic [NUM_REGS-1:0][DBUS_WIDTH-1:0]  r_regs;
  logic [NUM_REGS-1:0][DBUS_WIDTH-1:0]  w_regs_nxt;

  logic [DBUS_WIDTH-1:0]                r_rdata;
  logic [NUM_REGS-1:0]                  r_wr_pulse;
  logic                                 r_irq;

  logic                                 w_hit;
  logic                                 w_accept;
  logic [REG_ADDR_WIDTH-1:0]            w_idx;
  logic [NUM_REGS-1:0]                  w_bus_wr;
  logic [DBUS_WIDTH-1:0]                w_rd_mux;
  logic [DBUS_WIDTH-1:0]                w_clr_mask;

  // INT_EN and INT_STATUS are never loaded through the peripheral write
  // ports, so those enable bits and data lanes are intentionally unused.
  logic                                 w_unused_ok;
  assign w_unused_ok = ^{slv_wr_en[1:0], slv_wr_data[2*DBUS_WIDTH-1:0]};

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_hit    = hba_select && (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == c_PERIPH);
  assign w_idx    = hba_abus[REG_ADDR_WIDTH-1:0];
  // A transfer is only taken in IDLE; a select held through ACK/WAIT_DESEL
  // belongs to the transfer already answered.
  assign w_accept = (r_state == c_ST_IDLE) && w_hit;

  // One-hot bus write decode. An index beyond the bank matches no bit, so
  // such writes are acknowledged but change nothing.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_dec
      assign w_bus_wr[gi] = w_accept && !hba_rnw && (w_idx == REG_ADDR_WIDTH'(gi));
    end
  endgenerate

  // Read mux; out-of-range indices fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == REG_ADDR_WIDTH'(i)) begin
        w_rd_mux = r_regs[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt = c_ST_ACK;
        end
      end
      c_ST_ACK: begin
        w_state_nxt = c_ST_WAIT_DESEL;
      end
      c_ST_WAIT_DESEL: begin
        if (!hba_select) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    hba_xferack_slave = 1'b0;
    hba_dbus_slave    = '0;
    if (r_state == c_ST_ACK) begin
      hba_xferack_slave = 1'b1;
      hba_dbus_slave    = r_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Register bank next-state
  // --------------------------------------------------------------------------
  // Bits written as 1 by the bus clear INT_STATUS.
  assign w_clr_mask = w_bus_wr[c_IDX_INT_STATUS] ? hba_dbus : '0;

  always_comb begin
    w_regs_nxt = r_regs;

    if (w_bus_wr[c_IDX_INT_EN]) begin
      w_regs_nxt[c_IDX_INT_EN] = hba_dbus;
    end

    // Set pulses are applied after the clear so a coincident set wins.
    w_regs_nxt[c_IDX_INT_STATUS] = (r_regs[c_IDX_INT_STATUS] & ~w_clr_mask) | slv_int_set;

    // General registers: the bus has priority over the peripheral port.
    for (int i = 2; i < NUM_REGS; i++) begin
      if (w_bus_wr[i]) begin
        w_regs_nxt[i] = hba_dbus;
      end else if (slv_wr_en[i]) begin
        w_regs_nxt[i] = slv_wr_data[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) begin
      r_regs     <= '0;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_regs     <= w_regs_nxt;
      r_wr_pulse <= w_bus_wr;
      // Captures the pre-update contents so a same-edge peripheral load
      // does not leak into the returned data.
      if (w_accept) begin
        r_rdata <= hba_rnw ? w_rd_mux : '0;
      end
      r_irq      <= |(r_regs[c_IDX_INT_EN] & r_regs[c_IDX_INT_STATUS]);
    end
  end

  assign slv_regs            = r_regs;
  assign reg_wr_pulse        = r_wr_pulse;
  assign hba_interrupt_slave = r_irq;

endmodule
`default_nettype wire
